// File: rtl/hack_rom_pkg.sv
// Shared types and default sizes for the instruction ROM and the logic around it.
// Includes the owner tag carried alongside every in-flight ROM read.
package hack_rom_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam int HACK_ADDR_W      = 16;
  localparam int HACK_ROM_ADDR_W  = 32;
  localparam int HACK_DATA_W      = 16;
  localparam int HACK_ROM_LATENCY = 1;

  // Maps the one-hot grant pair onto the tag that follows the read.
  function automatic owner_t grant_owner(input logic cpu_g, input logic dbg_g);
    owner_t own;
    if (cpu_g) begin
      own = OWN_CPU;
    end else if (dbg_g) begin
      own = OWN_DBG;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Shift register of read owners, aligned with the ROM read latency.
// Reset discards every in-flight tag.
module rom_tag_pipe
  import hack_rom_pkg::*;
#(
  parameter int DEPTH = HACK_ROM_LATENCY
) (
  input  logic   clock,
  input  logic   reset,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [DEPTH];

  // Advance tags one stage per cycle; the tail lines up with valid ROM data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates the single-port instruction ROM between CPU fetch and the debug reader.
// Define ROM_ARB_STARVE_EN to force a debug win after STARVE_LIMIT denied cycles.
module rom_read_arbiter
  import hack_rom_pkg::*;
#(
  parameter int ADDR_W       = HACK_ADDR_W,
  parameter int ROM_ADDR_W   = HACK_ROM_ADDR_W,
  parameter int DATA_W       = HACK_DATA_W,
  parameter int ROM_LATENCY  = HACK_ROM_LATENCY,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_W-1:0]     cpu_addr,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  rom_en,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]     rom_dout
);

  logic                  force_dbg_s;
  logic                  cpu_gnt_s;
  logic                  dbg_gnt_s;
  logic [ROM_ADDR_W-1:0] rom_addr_s;
  owner_t                tail_s;
  logic                  cpu_rvalid_s;
  logic                  dbg_rvalid_s;
  logic [DATA_W-1:0]     cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]     dbg_hold_q, dbg_hold_d;

`ifdef ROM_ARB_STARVE_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  // Count consecutive cycles debug waits; any grant or dropped request clears it.
  always_comb begin
    if (dbg_req && !dbg_gnt_s) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = 8'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_dbg_s = (starve_cnt_q == 8'(STARVE_LIMIT));
`else
  logic unused_limit_s;
  assign unused_limit_s = ^(8'(STARVE_LIMIT));
  assign force_dbg_s    = 1'b0;
`endif

  // CPU has priority unless debug has waited long enough; nothing granted in reset.
  always_comb begin
    cpu_gnt_s = 1'b0;
    dbg_gnt_s = 1'b0;
    if (reset) begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end else if (dbg_req && (force_dbg_s || !cpu_req)) begin
      dbg_gnt_s = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end
  end

  // Winner address, zero-extended onto the ROM address bus.
  always_comb begin
    rom_addr_s = '0;
    if (cpu_gnt_s) begin
      rom_addr_s[ADDR_W-1:0] = cpu_addr;
    end else if (dbg_gnt_s) begin
      rom_addr_s[ADDR_W-1:0] = dbg_addr;
    end else begin
      rom_addr_s = '0;
    end
  end

  rom_tag_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .tag_i (grant_owner(cpu_gnt_s, dbg_gnt_s)),
    .tag_o (tail_s)
  );

  // Gate with reset so a tag still at the tail during reset never pulses.
  assign cpu_rvalid_s = (tail_s == OWN_CPU) && !reset;
  assign dbg_rvalid_s = (tail_s == OWN_DBG) && !reset;

  // Capture returned data so each read port holds its last word.
  always_comb begin
    cpu_hold_d = cpu_hold_q;
    dbg_hold_d = dbg_hold_q;
    if (cpu_rvalid_s) begin
      cpu_hold_d = rom_dout;
    end else if (dbg_rvalid_s) begin
      dbg_hold_d = rom_dout;
    end else begin
      cpu_hold_d = cpu_hold_q;
      dbg_hold_d = dbg_hold_q;
    end
  end

  // Held read data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign rom_en     = cpu_gnt_s | dbg_gnt_s;
  assign rom_addr   = rom_addr_s;
  assign cpu_rvalid = cpu_rvalid_s;
  assign dbg_rvalid = dbg_rvalid_s;
  assign cpu_rdata  = reset ? '0 : (cpu_rvalid_s ? rom_dout : cpu_hold_q);
  assign dbg_rdata  = reset ? '0 : (dbg_rvalid_s ? rom_dout : dbg_hold_q);

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares the single-port synchronous instruction ROM between two requesters: the CPU instruction fetch (primary) and the segment-display debug reader (secondary), which walks ROM contents for the seven-segment display. Sits between the CPU/segdisplay logic and the ROM core (clka/ena/addra/douta). Issues at most one ROM read per cycle, tracks the owner of every in-flight read, and returns data to the correct requester after the fixed ROM latency. Prevents debug starvation under continuous CPU fetch.

## Interface
- ADDR_W, 16, requester address width (matches `pc`)
- ROM_ADDR_W, 32, ROM `addra` width; requester address zero-extended
- DATA_W, 16, instruction width
- ROM_LATENCY, 1, cycles from address sampled to valid `douta` (1..4)
- STARVE_LIMIT, 8, consecutive denied debug cycles before debug is forced to win (2..255)

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU read request, level, held until `cpu_gnt`
- cpu_addr  in  ADDR_W  CPU read address
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  `cpu_rdata` valid, one-cycle pulse per grant
- cpu_rdata  out  DATA_W  read data
- dbg_req  in  1  debug read request, level, held until `dbg_gnt`
- dbg_addr  in  ADDR_W  debug read address
- dbg_gnt  out  1  request accepted this cycle (combinational)
- dbg_rvalid  out  1  `dbg_rdata` valid pulse
- dbg_rdata  out  DATA_W  read data
- rom_en  out  1  to ROM `ena`; high in any cycle a grant is issued
- rom_addr  out  ROM_ADDR_W  to ROM `addra`; `{zeros, winner_addr}`
- rom_dout  in  DATA_W  from ROM `douta`

## Operation
- Each cycle, at most one of `cpu_gnt`/`dbg_gnt` high; grant only if matching req high.
- Default priority: CPU wins when both request.
- Starvation counter `starve_cnt` (8 bits): increments each cycle `dbg_req && !dbg_gnt`; clears on `dbg_gnt` or `!dbg_req`. When `starve_cnt == STARVE_LIMIT`, debug wins arbitration that cycle regardless of `cpu_req`.
- Winner state register `owner` ∈ {OWN_NONE, OWN_CPU, OWN_DBG} enters a tag shift pipeline of depth ROM_LATENCY; tag at tail selects which `*_rvalid` pulses.
- `rom_addr`/`rom_en` combinational from winner; with no grant `rom_en=0`, `rom_addr=0`.
- `cpu_rdata`/`dbg_rdata` driven from `rom_dout` when their rvalid is high, else hold last value.
- Requester may change addr/req after seeing gnt; back-to-back grants to same requester allowed every cycle.

## Timing
- Reset values: `cpu_rvalid=0`, `dbg_rvalid=0`, `cpu_rdata=0`, `dbg_rdata=0`, `starve_cnt=0`, all tags OWN_NONE. `cpu_gnt`/`dbg_gnt`/`rom_en` follow inputs combinationally but are forced 0 while `reset=1`.
- Read latency: grant in cycle N → rvalid in cycle N+ROM_LATENCY.
- Throughput: one read per cycle total, sustained.
- Reset mid-operation: all in-flight tags discarded; no rvalid pulses after reset even though ROM still returns data.
- Simultaneous request with `starve_cnt == STARVE_LIMIT`: debug granted, CPU stalls exactly one cycle, counter clears.
- Request dropped without grant: no side effects; counter clears.

## Configuration
- `ROM_ARB_STARVE_EN` defined: starvation counter and forced debug win as above.
- Not defined: pure fixed priority, CPU always wins; `starve_cnt` and its logic absent; debug served only in cycles with `cpu_req=0`. STARVE_LIMIT ignored.

## Structure
- Package `hack_rom_pkg`: `owner_t` enum (OWN_NONE, OWN_CPU, OWN_DBG), default ADDR_W/DATA_W/ROM_ADDR_W constants, ROM latency constant shared with the ROM wrapper.
- Sub-module `rom_tag_pipe`: ROM_LATENCY-deep shift register of `owner_t`, synchronous clear on reset; arbitration and counter stay in the top.

## Test plan
- Reset then CPU single read: `cpu_req=1, cpu_addr=16'h0000` one cycle → `cpu_gnt=1`, `rom_addr=32'h0`, `rom_en=1`; next cycle `cpu_rvalid=1`, `cpu_rdata=` ROM word 0 (16'h0000).
- Back-to-back CPU reads addrs 0,1,2,3 → four consecutive `cpu_rvalid` pulses, data in order, no bubbles.
- Both request continuously, STARVE_LIMIT=8, macro on → `dbg_gnt` on 9th cycle, CPU stalls one cycle, pattern repeats every 9 cycles; macro off → `dbg_gnt` never asserts.
- Debug alone, `dbg_addr=16'h0005` → `dbg_rvalid` one cycle after grant with ROM word 5; `cpu_rvalid` stays 0.
- Reset asserted the cycle after a CPU grant → no `cpu_rvalid` pulse; outputs at reset values next cycle.
- ROM_LATENCY=2 variant: interleaved CPU/debug grants → each rvalid exactly 2 cycles after its grant, routed to correct requester.
